// File: rtl/sha256_top.sv
`default_nettype none
// ============================================================================
// Module   : sha256_top
// Brief    : Single-block SHA-256 hasher, one compression round per clock.
//            Optional `done` output when SHA256_DONE_PORT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_top #(
  parameter int MSG_SIZE    = 120,
  parameter int PADDED_SIZE = 512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MSG_SIZE-1:0] message,
  output logic [255:0]        hashed
`ifdef SHA256_DONE_PORT_EN
  ,
  output logic                done
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [31:0] C_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] C_H0 = 32'h6a09e667;
  localparam logic [31:0] C_H1 = 32'hbb67ae85;
  localparam logic [31:0] C_H2 = 32'h3c6ef372;
  localparam logic [31:0] C_H3 = 32'ha54ff53a;
  localparam logic [31:0] C_H4 = 32'h510e527f;
  localparam logic [31:0] C_H5 = 32'h9b05688c;
  localparam logic [31:0] C_H6 = 32'h1f83d9ab;
  localparam logic [31:0] C_H7 = 32'h5be0cd19;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [1:0]  r_state;
  logic [5:0]  r_t;
  logic [31:0] r_w [0:15];
  logic [31:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;

  // Block = message, a single 1 bit, zero fill, then the 64-bit length.
  logic [PADDED_SIZE-1:0] w_block;
  assign w_block = {{message, 1'b1}, {(PADDED_SIZE - MSG_SIZE - 1){1'b0}}}
                 | {{(PADDED_SIZE - 64){1'b0}}, 64'(MSG_SIZE)};

  logic [31:0] w_s0, w_s1, w_ch, w_maj, w_t1, w_t2, w_a_nxt, w_e_nxt, w_w_nxt;
  assign w_s1    = rotr(r_e, 6) ^ rotr(r_e, 11) ^ rotr(r_e, 25);
  assign w_ch    = (r_e & r_f) ^ (~r_e & r_g);
  assign w_t1    = r_h + w_s1 + w_ch + C_K[r_t] + r_w[0];
  assign w_s0    = rotr(r_a, 2) ^ rotr(r_a, 13) ^ rotr(r_a, 22);
  assign w_maj   = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
  assign w_t2    = w_s0 + w_maj;
  assign w_a_nxt = w_t1 + w_t2;
  assign w_e_nxt = r_d + w_t1;

  // Window slot 0 always holds W[t]; the new word W[t+16] enters at slot 15.
  assign w_w_nxt = (rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10))
                 + r_w[9]
                 + (rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3))
                 + r_w[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_t     <= 6'd0;
      hashed  <= 256'd0;
      for (int i = 0; i < 16; i++) r_w[i] <= 32'd0;
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= 256'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_LOAD;
        end
        S_LOAD: begin
          for (int i = 0; i < 16; i++) r_w[i] <= w_block[PADDED_SIZE-1-32*i -: 32];
          {r_a, r_b, r_c, r_d} <= {C_H0, C_H1, C_H2, C_H3};
          {r_e, r_f, r_g, r_h} <= {C_H4, C_H5, C_H6, C_H7};
          r_t     <= 6'd0;
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
          r_w[15] <= w_w_nxt;
          {r_a, r_b, r_c, r_d} <= {w_a_nxt, r_a, r_b, r_c};
          {r_e, r_f, r_g, r_h} <= {w_e_nxt, r_e, r_f, r_g};
          r_t <= r_t + 6'd1;
          if (r_t == 6'd63) begin
            hashed  <= {C_H0 + w_a_nxt, C_H1 + r_a, C_H2 + r_b, C_H3 + r_c,
                        C_H4 + w_e_nxt, C_H5 + r_e, C_H6 + r_f, C_H7 + r_g};
            r_state <= S_DONE;
          end
        end
        default: begin
          if (!start) r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SHA256_DONE_PORT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done <= 1'b0;
    else        done <= ((r_state == S_ROUND) && (r_t == 6'd63)) || ((r_state == S_DONE) && start);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha256_top.sv
`default_nettype none
// Testbench for sha256_top: two instances (120-bit and 24-bit messages) driven
// with directed vectors and compared against known digests.
`timescale 1ns/1ps
module tb_sha256_top;

  localparam logic [255:0] C_D_HELLO = 256'hd0e8b8f11c98f369016eb2ed3c541e1f01382f9d5b3104c9ffd06b6175a46271;
  localparam logic [255:0] C_D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [119:0] C_M_HELLO = 120'h48656c6c6f2c205348412d32353621;
  localparam logic [119:0] C_M_JUNK  = 120'hdeadbeef0123456789abcdef5a5a5a;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic [119:0] msg_a = C_M_HELLO;
  logic [23:0]  msg_b = 24'h616263;
  logic [255:0] hashed_a, hashed_b;
`ifdef SHA256_DONE_PORT_EN
  logic         done_a, done_b;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  sha256_top #(.MSG_SIZE(120), .PADDED_SIZE(512)) u_dut_a (
    .clk     (clk),
    .reset   (reset),
    .start   (start_a),
    .message (msg_a),
    .hashed  (hashed_a)
`ifdef SHA256_DONE_PORT_EN
    ,
    .done    (done_a)
`endif
  );

  sha256_top #(.MSG_SIZE(24), .PADDED_SIZE(512)) u_dut_b (
    .clk     (clk),
    .reset   (reset),
    .start   (start_b),
    .message (msg_b),
    .hashed  (hashed_b)
`ifdef SHA256_DONE_PORT_EN
    ,
    .done    (done_b)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #21 reset = 1'b1;
    @(negedge clk);
    chk("reset_a", hashed_a, 256'd0);
    chk("reset_b", hashed_b, 256'd0);

    // Run 1: both instances start together; b gets a single-cycle pulse.
    start_a = 1'b1;
    start_b = 1'b1;
    cycles(1);
    start_b = 1'b0;
`ifdef SHA256_DONE_PORT_EN
    chk("done_load", 256'(done_a), 256'd0);
`endif
    cycles(30);
    chk("mid_run1_a", hashed_a, 256'd0);
`ifdef SHA256_DONE_PORT_EN
    chk("done_round", 256'(done_a), 256'd0);
`endif
    cycles(36);
    chk("hello", hashed_a, C_D_HELLO);
    chk("abc", hashed_b, C_D_ABC);
`ifdef SHA256_DONE_PORT_EN
    chk("done_set", 256'(done_a), 256'd1);
`endif

    // Holding start in DONE must not rehash, even with a new message present.
    msg_a = C_M_JUNK;
    cycles(80);
    chk("hold_no_rehash", hashed_a, C_D_HELLO);
    chk("abc_stable", hashed_b, C_D_ABC);

    // Run 2: new message; old digest stays visible until completion.
    start_a = 1'b0;
    cycles(1);
`ifdef SHA256_DONE_PORT_EN
    chk("done_clear", 256'(done_a), 256'd0);
`endif
    cycles(1);
    start_a = 1'b1;
    cycles(31);
    chk("old_digest_kept", hashed_a, C_D_HELLO);
    cycles(36);
    chk("new_digest_differs", 256'(hashed_a != C_D_HELLO), 256'd1);
    chk("new_digest_nonzero", 256'(hashed_a != 256'd0), 256'd1);

    // Run 3: start dropped during LOAD, message corrupted mid-ROUND.
    start_a = 1'b0;
    msg_a   = C_M_HELLO;
    cycles(2);
    start_a = 1'b1;
    cycles(1);
    start_a = 1'b0;
    cycles(10);
    msg_a = C_M_JUNK;
    cycles(20);
    chk("junk_digest_kept", 256'(hashed_a != C_D_HELLO), 256'd1);
    cycles(36);
    chk("latched_msg", hashed_a, C_D_HELLO);

    // Run 4: reset mid-ROUND aborts immediately and returns to IDLE.
    msg_a   = C_M_HELLO;
    start_a = 1'b1;
    cycles(20);
    reset   = 1'b0;
    start_a = 1'b0;
    #1;
    chk("async_reset_a", hashed_a, 256'd0);
    chk("async_reset_b", hashed_b, 256'd0);
    cycles(2);
    reset = 1'b1;
    cycles(80);
    chk("idle_after_reset", hashed_a, 256'd0);
    start_a = 1'b1;
    cycles(67);
    chk("rehash_after_reset", hashed_a, C_D_HELLO);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
